// File: rtl/sdram_av_responder_pkg.sv
// Shared types and constants for the SDRAM Avalon responder.
// The LFSR constants are used only when SDRAM_AV_RESPONDER_RANDOM_STALL_EN is defined.
package sdram_av_responder_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_ACTIVE,
    S_REF_PEND,
    S_REFRESH
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned cnt_bits(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// Fixed-latency read return pipeline: valid/data shift register with flush.
// The output data stage only advances on valid entries, so it holds between reads.
module sdram_rd_pipe #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned W       = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         any_valid_o
);

  logic [LATENCY-1:0] vld_q;
  logic [W-1:0]       dat_q [LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= push_i && !flush_i;
      if (push_i && !flush_i) dat_q[0] <= data_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1] && !flush_i;
        if (vld_q[i-1] && !flush_i) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o     = vld_q[LATENCY-1];
  assign data_o      = dat_q[LATENCY-1];
  assign any_valid_o = |vld_q;

endmodule

// File: rtl/sdram_av_responder.sv
// Avalon-MM slave emulating the SDRAM controller bus side on on-chip RAM.
// Optional random stalls: define SDRAM_AV_RESPONDER_RANDOM_STALL_EN.
module sdram_av_responder
  import sdram_av_responder_pkg::*;
#(
  parameter int unsigned AV_ADDR_BITS   = 24,
  parameter int unsigned AV_BUS_BITS    = 16,
  parameter int unsigned MEM_DEPTH_BITS = 12,
  parameter int unsigned READ_LATENCY   = 3,
  parameter int unsigned INIT_CYCLES    = 64,
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned REFRESH_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic [AV_ADDR_BITS-1:0]  av_address,
  input  logic [AV_BUS_BITS/8-1:0] av_byteenable_n,
  input  logic                     av_chipselect,
  input  logic [AV_BUS_BITS-1:0]   av_writedata,
  input  logic                     av_read_n,
  input  logic                     av_write_n,
  output logic [AV_BUS_BITS-1:0]   av_readdata,
  output logic                     av_readdatavalid,
  output logic                     av_waitrequest,
  output logic                     protocol_err
);

  localparam int unsigned LANES    = AV_BUS_BITS / 8;
  localparam int unsigned CNT_BITS = cnt_bits(INIT_CYCLES, REFRESH_PERIOD, REFRESH_CYCLES);
  localparam logic [CNT_BITS-1:0] INIT_LD   = CNT_BITS'(INIT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] PERIOD_LD = CNT_BITS'(REFRESH_PERIOD - 1);
  localparam logic [CNT_BITS-1:0] REFCYC_LD = CNT_BITS'(REFRESH_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

  state_e                    state_q, state_d;
  logic [CNT_BITS-1:0]       cnt_q, cnt_d;
  logic                      perr_q, perr_d;
  logic [AV_BUS_BITS-1:0]    mem [2**MEM_DEPTH_BITS];
  logic [MEM_DEPTH_BITS-1:0] maddr;
  logic                      stall, acc, rd_acc, wr_acc, illegal, any_valid;
  logic                      unused_addr;

`ifdef SDRAM_AV_RESPONDER_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    if (sync_reset) lfsr_d = LFSR_SEED;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[3:0] == 4'd0);
`else
  assign stall = 1'b0;
`endif

  // Moore: derived from registered state only, never from the strobes
  assign av_waitrequest = (state_q != S_ACTIVE) || stall;

  assign illegal = av_chipselect && !av_read_n && !av_write_n;
  assign acc     = av_chipselect && !av_waitrequest && (av_read_n != av_write_n) && !sync_reset;
  assign rd_acc  = acc && !av_read_n;
  assign wr_acc  = acc && !av_write_n;
  assign maddr   = av_address[MEM_DEPTH_BITS-1:0];
  assign unused_addr = ^av_address[AV_ADDR_BITS-1:MEM_DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!av_byteenable_n[i]) mem[maddr][i*8 +: 8] <= av_writedata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q || illegal;
    if (sync_reset) begin
      state_d = S_INIT;
      cnt_d   = INIT_LD;
      perr_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          if (cnt_q == '0) begin
            state_d = S_ACTIVE;
            cnt_d   = PERIOD_LD;
          end else cnt_d = cnt_q - CNT_ONE;
        end
        S_ACTIVE: begin
          if (cnt_q == '0) state_d = S_REF_PEND;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        S_REF_PEND: begin
          if (!any_valid) begin
            state_d = S_REFRESH;
            cnt_d   = REFCYC_LD;
          end
        end
        S_REFRESH: begin
          if (cnt_q == '0) begin
            state_d = S_ACTIVE;
            cnt_d   = PERIOD_LD;
          end else cnt_d = cnt_q - CNT_ONE;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= INIT_LD;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

  assign protocol_err = perr_q;

  sdram_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .W       (AV_BUS_BITS)
  ) u_rd_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (sync_reset),
    .push_i      (rd_acc),
    .data_i      (mem[maddr]),
    .valid_o     (av_readdatavalid),
    .data_o      (av_readdata),
    .any_valid_o (any_valid)
  );

endmodule

// File: tb/tb_sdram_av_responder.sv
// Directed self-checking bench for sdram_av_responder (default build, no random stalls).
module tb_sdram_av_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_reset = 1'b0;
  logic [23:0] av_address = '0;
  logic [1:0]  av_byteenable_n = '1;
  logic        av_chipselect = 1'b0;
  logic [15:0] av_writedata = '0;
  logic        av_read_n = 1'b1;
  logic        av_write_n = 1'b1;
  logic [15:0] av_readdata;
  logic        av_readdatavalid;
  logic        av_waitrequest;
  logic        protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_av_responder #(
    .AV_ADDR_BITS   (24),
    .AV_BUS_BITS    (16),
    .MEM_DEPTH_BITS (12),
    .READ_LATENCY   (3),
    .INIT_CYCLES    (64),
    .REFRESH_PERIOD (780),
    .REFRESH_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sync_reset       (sync_reset),
    .av_address       (av_address),
    .av_byteenable_n  (av_byteenable_n),
    .av_chipselect    (av_chipselect),
    .av_writedata     (av_writedata),
    .av_read_n        (av_read_n),
    .av_write_n       (av_write_n),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .av_waitrequest   (av_waitrequest),
    .protocol_err     (protocol_err)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    av_chipselect   = 1'b0;
    av_read_n       = 1'b1;
    av_write_n      = 1'b1;
    av_byteenable_n = '1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 2000 && av_waitrequest; i++) @(negedge clk);
    expect_eq(tag, av_waitrequest, 1'b0);
  endtask

  task automatic count_high(output int n, output int vseen);
    n = 0;
    vseen = 0;
    while (av_waitrequest && n < 2000) begin
      if (av_readdatavalid) vseen++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!av_waitrequest && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [23:0] a, input logic [15:0] d, input logic [1:0] ben);
    wait_ready("wr_ready");
    av_address      = a;
    av_writedata    = d;
    av_byteenable_n = ben;
    av_chipselect   = 1'b1;
    av_write_n      = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic bus_read_chk(input string tag, input logic [23:0] a, input logic [15:0] exp);
    int          lat;
    logic [15:0] got;
    lat = 0;
    got = '0;
    wait_ready({tag, "_ready"});
    av_address      = a;
    av_chipselect   = 1'b1;
    av_read_n       = 1'b0;
    av_byteenable_n = 2'b11;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) idle();
      if (av_readdatavalid) begin
        lat = k;
        got = av_readdata;
      end
    end
    expect_eq({tag, "_lat"}, lat, 3);
    expect_eq({tag, "_data"}, got, exp);
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, v, first, last, nv, hi, lat;
    logic [15:0] got;
    logic [15:0] b2b [4];

    #12;
    expect_eq("rst_wait", av_waitrequest, 1'b1);
    expect_eq("rst_valid", av_readdatavalid, 1'b0);
    expect_eq("rst_data", av_readdata, 16'h0000);
    expect_eq("rst_perr", protocol_err, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    count_high(n, v);
    expect_eq("init_len", n, 64);
    expect_eq("init_novalid", v, 0);

    // Byte-lane merge: only the upper lane of the second write lands
    bus_write(24'h10, 16'hBEEF, 2'b00);
    bus_write(24'h10, 16'h12AB, 2'b01);
    bus_read_chk("merge", 24'h10, 16'h12EF);

    for (int i = 0; i < 4; i++) bus_write(24'(i), 16'h1111 * 16'(i + 1), 2'b00);
    wait_ready("b2b_ready");
    nv = 0; first = -1; last = -1;
    for (int k = 0; k < 12; k++) begin
      if (av_readdatavalid) begin
        if (nv < 4) b2b[nv] = av_readdata;
        if (first < 0) first = k;
        last = k;
        nv++;
      end
      if (k < 4) begin
        av_address    = 24'(k);
        av_chipselect = 1'b1;
        av_read_n     = 1'b0;
      end else idle();
      @(negedge clk);
    end
    expect_eq("b2b_first", first, 3);
    expect_eq("b2b_last", last, 6);
    expect_eq("b2b_count", nv, 4);
    for (int i = 0; i < 4; i++) expect_eq("b2b_data", b2b[i], 16'h1111 * 16'(i + 1));

    // Aliasing: bit 12 and above ignored
    bus_read_chk("alias", 24'h001010, 16'h12EF);

    bus_write(24'h20, 16'h5A5A, 2'b00);
    wait_ready("ill_ready");
    expect_eq("perr_before", protocol_err, 1'b0);
    av_address      = 24'h20;
    av_writedata    = 16'hFFFF;
    av_byteenable_n = 2'b00;
    av_chipselect   = 1'b1;
    av_read_n       = 1'b0;
    av_write_n      = 1'b0;
    @(posedge clk);
    #1;
    expect_eq("perr_set", protocol_err, 1'b1);
    @(negedge clk);
    idle();
    bus_read_chk("ill_rb", 24'h20, 16'h5A5A);
    expect_eq("perr_sticky", protocol_err, 1'b1);

    for (int i = 0; i < 1000 && !av_waitrequest; i++) @(negedge clk);
    expect_eq("ref1_start", av_waitrequest, 1'b1);
    count_high(n, v);
    expect_eq("ref1_len", n, 9);

    repeat (779) @(negedge clk);
    expect_eq("last_active_ready", av_waitrequest, 1'b0);
    av_address    = 24'h10;
    av_chipselect = 1'b1;
    av_read_n     = 1'b0;
    @(negedge clk);
    idle();
    expect_eq("ref_after_last", av_waitrequest, 1'b1);
    hi = 0; lat = 0; got = '0;
    while (av_waitrequest && hi < 100) begin
      if (av_readdatavalid && lat == 0) begin
        lat = hi + 1;
        got = av_readdata;
      end
      hi++;
      @(negedge clk);
    end
    expect_eq("ref_rd_lat", lat, 3);
    expect_eq("ref_rd_data", got, 16'h12EF);
    expect_eq("ref2_len", hi, 12);
    count_low(n);
    expect_eq("active_period", n, 780);

    wait_ready("sr_ready");
    av_address    = 24'h10;
    av_chipselect = 1'b1;
    av_read_n     = 1'b0;
    @(negedge clk);
    idle();
    expect_eq("perr_held", protocol_err, 1'b1);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    expect_eq("sr_perr_clr", protocol_err, 1'b0);
    count_high(n, v);
    expect_eq("sr_init_len", n, 64);
    expect_eq("sr_novalid", v, 0);

    wait_ready("ar_ready");
    av_address    = 24'h10;
    av_chipselect = 1'b1;
    av_read_n     = 1'b0;
    @(negedge clk);
    idle();
    #2 reset_n = 1'b0;
    #1;
    expect_eq("ar_valid", av_readdatavalid, 1'b0);
    expect_eq("ar_wait", av_waitrequest, 1'b1);
    expect_eq("ar_data", av_readdata, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    count_high(n, v);
    expect_eq("ar_init_len", n, 64);
    expect_eq("ar_novalid", v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_av_responder.md
Name: sdram_av_responder

Overview:
- Synthesizable Avalon-MM slave that emulates the SDRAM controller side of the 16-bit SDRAM Avalon bus (active-low read_n/write_n/byteenable_n, chipselect, waitrequest, readdatavalid).
- Backed by on-chip RAM. Produces fixed-latency pipelined reads, power-up init stall and periodic refresh stalls.
- Used as the bus endpoint for the MCU memory path in FPGA builds without SDRAM and in simulation.

Parameters:
- AV_ADDR_BITS, 24, width of av_address (16-bit word address).
- AV_BUS_BITS, 16, data bus width; must be a multiple of 8.
- MEM_DEPTH_BITS, 12, log2 of backing RAM words; address bits above this are ignored (aliasing).
- READ_LATENCY, 3, cycles from read accept to av_readdatavalid; legal range 1..7.
- INIT_CYCLES, 64, waitrequest-high cycles after reset/sync_reset.
- REFRESH_PERIOD, 780, cycles between refresh requests.
- REFRESH_CYCLES, 8, waitrequest-high cycles per refresh.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- sync_reset  in  1  synchronous reset, active-high
- av_address  in  AV_ADDR_BITS  word address
- av_byteenable_n  in  AV_BUS_BITS/8  byte-lane enables, active-low
- av_chipselect  in  1  request qualifier
- av_writedata  in  AV_BUS_BITS  write data
- av_read_n  in  1  read strobe, active-low
- av_write_n  in  1  write strobe, active-low
- av_readdata  out  AV_BUS_BITS  read data
- av_readdatavalid  out  1  read data qualifier
- av_waitrequest  out  1  stall
- protocol_err  out  1  sticky illegal-request flag

Behaviour:
- Reset: reset_n is asynchronous, active-low; clk is the clock. Reset values: av_waitrequest=1, av_readdatavalid=0, av_readdata=0, protocol_err=0, FSM=S_INIT, init counter=INIT_CYCLES-1. RAM contents are not reset.
- av_waitrequest is a pure function of registered state (Moore). It never depends combinationally on request inputs, because the initiator gates its strobes on waitrequest.
- Accept: a request is accepted in a cycle with av_chipselect=1, av_waitrequest=0 and exactly one of av_read_n/av_write_n low.
- Illegal request: chipselect=1 with both strobes low. Ignored; protocol_err set (sticky) in the next cycle.
- Write: RAM lane i is written at the accept edge iff av_byteenable_n[i]=0. Write data is visible to any read accepted in the following cycle or later.
- Read: RAM is read at the accept edge. av_readdatavalid=1 with data exactly READ_LATENCY cycles after the accept edge. One read may be accepted per cycle; back-to-back reads return in order on consecutive cycles. Byteenables are ignored for reads; the full word is returned. av_readdata holds its last value when valid=0.
- FSM states and transitions:
  - S_INIT: waitrequest=1. Counter decrements; at 0 go to S_ACTIVE and load refresh counter = REFRESH_PERIOD-1.
  - S_ACTIVE: waitrequest=0. Refresh counter decrements each cycle; at 0 go to S_REF_PEND. A request in that final cycle is still accepted.
  - S_REF_PEND: waitrequest=1. Stay until the read pipeline holds no valid entries, then go to S_REFRESH with counter = REFRESH_CYCLES-1.
  - S_REFRESH: waitrequest=1. At counter 0 go to S_ACTIVE and reload the refresh counter.
- Refresh counter runs only in S_ACTIVE. Refresh interval measured in S_ACTIVE is exactly REFRESH_PERIOD cycles.
- sync_reset: FSM to S_INIT, reload init counter, flush pipeline valid bits (readdatavalid=0 next cycle), clear protocol_err. Takes priority over any accept in the same cycle; no write occurs.
- Async reset mid-read: in-flight reads are discarded and never return valid.

Optional Feature:
- Macro: SDRAM_AV_RESPONDER_RANDOM_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reset and sync_reset reload the seed) advances every cycle. In S_ACTIVE, waitrequest=1 when lfsr[3:0]==0. The refresh counter still decrements during these stalls.
- Not defined: no LFSR; waitrequest in S_ACTIVE is constant 0.

Decomposition:
- Package sdram_av_responder_pkg: FSM state enum (S_INIT, S_ACTIVE, S_REF_PEND, S_REFRESH), LFSR seed/taps constants, counter width localparams derived via $clog2.
- One sub-module, sdram_rd_pipe: READ_LATENCY-deep valid/data shift pipeline with flush input and an any_valid output.

Test Plan:
- Reset release, no requests -> waitrequest=1 for exactly 64 cycles, then 0; readdatavalid stays 0.
- Write 16'hBEEF to addr 0x10 with byteenable_n=2'b00, then write 16'h12xx with byteenable_n=2'b01, then read 0x10 -> readdata=16'h12EF with valid exactly 3 cycles after accept.
- Four back-to-back reads of 0x0..0x3 holding 16'h1111..16'h4444 -> valid high for 4 consecutive cycles, data in order.
- Read accepted in the last S_ACTIVE cycle before refresh -> waitrequest=1 from the next cycle; data returns; S_REFRESH then lasts 8 cycles; waitrequest falls 780 S_ACTIVE cycles after the previous refresh.
- chipselect=1, read_n=0, write_n=0 at addr 0x20 -> RAM unchanged (readback equals prior value), protocol_err=1 next cycle and held until sync_reset.
- sync_reset one cycle after a read accept -> no readdatavalid for that read, waitrequest=1 for 64 cycles, protocol_err=0.
